// File: rtl/slow_clock_monitor.sv
//==============================================================================
// slow_clock_monitor
//------------------------------------------------------------------------------
// Fast-domain monitor for a divided clock. The divided clock is synchronised
// into the fast domain, its edges become single-cycle strobes, and its
// rise-to-rise period is measured in fast cycles. The lock flag rises once
// LOCK_COUNT consecutive periods match DIV_RATIO within TOL.
//
// Ports:
//   Clck        in   fast-domain clock (rising edge)
//   reset_Clock in   asynchronous active-high reset
//   Clck_slow   in   divided clock, asynchronous to Clck
//   rise_pulse  out  one-cycle strobe per slow rising edge
//   fall_pulse  out  one-cycle strobe per slow falling edge (FALL_EN build)
//   period      out  last rise-to-rise period in fast cycles
//   high_time   out  last rise-to-fall time in fast cycles (FALL_EN build)
//   locked      out  period stable within tolerance
//   timeout     out  sticky: no rising edge within 2^CNT_W-1 cycles
//
// Build option: define SLOW_CLOCK_MONITOR_FALL_EN to build the falling-edge
// path; otherwise fall_pulse and high_time are tied to zero.
//
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module slow_clock_monitor #(
   parameter int DIV_RATIO  = 2,
   parameter int TOL        = 0,
   parameter int LOCK_COUNT = 4,
   parameter int CNT_W      = 8
) (
   input  logic             Clck,
   input  logic             reset_Clock,
   input  logic             Clck_slow,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             locked,
   output logic             timeout
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]   c_cnt_max   = {CNT_W{1'b1}};
   localparam logic signed [CNT_W:0] c_div_ratio = (CNT_W+1)'(DIV_RATIO);
   localparam logic signed [CNT_W:0] c_tol       = (CNT_W+1)'(TOL);
   localparam logic [3:0]         c_lock_count = 4'(LOCK_COUNT);
   localparam logic [3:0]         c_good_max   = 4'd15;

   state_t           state_q, state_d;
   logic             s0_q, s1_q, s2_q;
   logic             rise_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       good_q, good_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             timeout_q, timeout_d;

   logic                    w_rise;
   logic signed [CNT_W:0]   w_diff;
   logic signed [CNT_W:0]   w_abs;
   logic                    w_in_tol;
   logic [3:0]              w_good_inc;

   assign w_rise = s1_q & ~s2_q;

   // Period minus the expected ratio, one bit wider so the sign survives.
   assign w_diff     = $signed({1'b0, cnt_q}) - c_div_ratio;
   assign w_abs      = w_diff[CNT_W] ? -w_diff : w_diff;
   assign w_in_tol   = (w_abs <= c_tol);
   assign w_good_inc = (good_q == c_good_max) ? good_q : good_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      good_d    = good_q;
      period_d  = period_q;
      timeout_d = timeout_q;

      if (w_rise) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q != c_cnt_max) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end

      case (state_q)
         ST_IDLE: begin
            // First rise only starts a measurement; period is left alone.
            if (w_rise) begin
               state_d = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            if (w_rise) begin
               period_d = cnt_q;
               if (w_in_tol) begin
                  good_d = w_good_inc;
                  if (w_good_inc >= c_lock_count) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  good_d = 4'd0;
               end
            end else if (cnt_q == c_cnt_max) begin
               timeout_d = 1'b1;
               good_d    = 4'd0;
               state_d   = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (w_rise) begin
               period_d = cnt_q;
               if (w_in_tol) begin
                  good_d = w_good_inc;
               end else begin
                  good_d  = 4'd0;
                  state_d = ST_MEASURE;
               end
            end else if (cnt_q == c_cnt_max) begin
               timeout_d = 1'b1;
               good_d    = 4'd0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            good_d  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge Clck or posedge reset_Clock) begin
      if (reset_Clock) begin
         s0_q      <= 1'b0;
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         rise_q    <= 1'b0;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         good_q    <= 4'd0;
         period_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         s0_q      <= Clck_slow;
         s1_q      <= s0_q;
         s2_q      <= s1_q;
         rise_q    <= w_rise;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         good_q    <= good_d;
         period_q  <= period_d;
         timeout_q <= timeout_d;
      end
   end

   assign rise_pulse = rise_q;
   assign period     = period_q;
   assign locked     = (state_q == ST_LOCKED);
   assign timeout    = timeout_q;

`ifdef SLOW_CLOCK_MONITOR_FALL_EN
   logic             w_fall;
   logic             fall_q;
   logic [CNT_W-1:0] high_time_q, high_time_d;

   assign w_fall = ~s1_q & s2_q;

   // High time is only meaningful once a rise has started a measurement.
   always_comb begin
      high_time_d = high_time_q;
      if (w_fall && (state_q != ST_IDLE)) begin
         high_time_d = cnt_q;
      end
   end

   always_ff @(posedge Clck or posedge reset_Clock) begin
      if (reset_Clock) begin
         fall_q      <= 1'b0;
         high_time_q <= '0;
      end else begin
         fall_q      <= w_fall;
         high_time_q <= high_time_d;
      end
   end

   assign fall_pulse = fall_q;
   assign high_time  = high_time_q;
`else
   assign fall_pulse = 1'b0;
   assign high_time  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slow_clock_monitor.sv
//==============================================================================
// tb_slow_clock_monitor
//------------------------------------------------------------------------------
// Bench for slow_clock_monitor. Three instances share clock and reset:
//   a: defaults, b: TOL=1, c: CNT_W=4. Each slow clock is driven from a
// period table; a behavioural model pushes expected period/locked/timeout
// per rising edge into a per-instance queue, popped on each rise_pulse.
//
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_slow_clock_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] slow = 3'b000;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rp_a, fp_a, lk_a, to_a;
   logic [7:0] per_a, ht_a;
   logic       rp_b, fp_b, lk_b, to_b;
   logic [7:0] per_b, ht_b;
   logic       rp_c, fp_c, lk_c, to_c;
   logic [3:0] per_c, ht_c;

   slow_clock_monitor #(.DIV_RATIO(2), .TOL(0), .LOCK_COUNT(4), .CNT_W(8)) u_dut_a (
      .Clck(clk), .reset_Clock(rst), .Clck_slow(slow[0]),
      .rise_pulse(rp_a), .fall_pulse(fp_a), .period(per_a),
      .high_time(ht_a), .locked(lk_a), .timeout(to_a));

   slow_clock_monitor #(.DIV_RATIO(2), .TOL(1), .LOCK_COUNT(4), .CNT_W(8)) u_dut_b (
      .Clck(clk), .reset_Clock(rst), .Clck_slow(slow[1]),
      .rise_pulse(rp_b), .fall_pulse(fp_b), .period(per_b),
      .high_time(ht_b), .locked(lk_b), .timeout(to_b));

   slow_clock_monitor #(.DIV_RATIO(2), .TOL(0), .LOCK_COUNT(4), .CNT_W(4)) u_dut_c (
      .Clck(clk), .reset_Clock(rst), .Clck_slow(slow[2]),
      .rise_pulse(rp_c), .fall_pulse(fp_c), .period(per_c),
      .high_time(ht_c), .locked(lk_c), .timeout(to_c));

   logic [2:0] rp_v, fp_v, lk_v, to_v;
   logic [7:0] per_v [3];
   logic [7:0] ht_v  [3];

   assign rp_v = {rp_c, rp_b, rp_a};
   assign fp_v = {fp_c, fp_b, fp_a};
   assign lk_v = {lk_c, lk_b, lk_a};
   assign to_v = {to_c, to_b, to_a};
   assign per_v[0] = per_a;
   assign per_v[1] = per_b;
   assign per_v[2] = {4'b0, per_c};
   assign ht_v[0]  = ht_a;
   assign ht_v[1]  = ht_b;
   assign ht_v[2]  = {4'b0, ht_c};

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic [7:0] per;
      logic       lk;
      logic       to;
   } exp_t;

   exp_t q0[$], q1[$], q2[$];

   int tol_p [3] = '{0, 1, 0};
   int cmax  [3] = '{255, 255, 15};
   int st    [3];   // 0 idle, 1 measure, 2 locked
   int good  [3];
   int mper  [3];
   int mto   [3];
   int last  [3];

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         st[d] = 0; good[d] = 0; mper[d] = 0; mto[d] = 0; last[d] = 0;
      end
      q0.delete(); q1.delete(); q2.delete();
   endtask

   task automatic model_rise(input int d);
      int   meas, diff;
      bit   ok;
      exp_t e;
      meas    = cyc - last[d];
      last[d] = cyc;
      // Counter saturated before this rise: the monitor has already timed out.
      if (st[d] != 0 && meas > cmax[d]) begin
         st[d] = 0; good[d] = 0; mto[d] = 1;
      end
      if (st[d] == 0) begin
         st[d] = 1;
      end else begin
         mper[d] = meas;
         diff = meas - 2;
         if (diff < 0) diff = -diff;
         ok = (diff <= tol_p[d]);
         if (ok) good[d] = (good[d] >= 15) ? 15 : good[d] + 1;
         else    good[d] = 0;
         if (st[d] == 1 && ok && good[d] >= 4) st[d] = 2;
         else if (st[d] == 2 && !ok)           st[d] = 1;
      end
      e.per = 8'(mper[d]);
      e.lk  = (st[d] == 2);
      e.to  = mto[d][0];
      case (d)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Drive n slow periods of p fast cycles with h cycles high; called at negedge.
   task automatic drive(input int d, input int p, input int h, input int n);
      for (int i = 0; i < n; i++) begin
         slow[d] = 1'b1;
         model_rise(d);
         repeat (h) @(negedge clk);
         slow[d] = 1'b0;
         repeat (p - h) @(negedge clk);
      end
   endtask

   // Wait for n rise strobes on instance d and compare each with the scoreboard.
   task automatic chk(input int d, input int n);
      exp_t e;
      bit   have;
      for (int i = 0; i < n; i++) begin
         int w = 0;
         @(negedge clk);
         while (!rp_v[d] && w < 40) begin
            @(negedge clk);
            w++;
         end
         checks++;
         if (!rp_v[d]) begin
            errors++;
            $display("FAIL rise_wait[%0d] #%0d: no rise_pulse within 40 cycles (required one)", d, i);
         end else begin
            have = 1'b0;
            case (d)
               0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
               1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
               default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
               errors++;
               $display("FAIL extra_rise[%0d] #%0d: rise_pulse=1 with empty scoreboard, required none", d, i);
            end else begin
               checks++;
               if (per_v[d] !== e.per) begin
                  errors++;
                  $display("FAIL period[%0d] #%0d: got %0d required %0d", d, i, per_v[d], e.per);
               end
               checks++;
               if (lk_v[d] !== e.lk) begin
                  errors++;
                  $display("FAIL locked[%0d] #%0d: got %0b required %0b", d, i, lk_v[d], e.lk);
               end
               checks++;
               if (to_v[d] !== e.to) begin
                  errors++;
                  $display("FAIL timeout[%0d] #%0d: got %0b required %0b", d, i, to_v[d], e.to);
               end
            end
            @(negedge clk);
            checks++;
            if (rp_v[d] !== 1'b0) begin
               errors++;
               $display("FAIL rise_width[%0d] #%0d: got rise_pulse=%0b required 0", d, i, rp_v[d]);
            end
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({rp_v[d], fp_v[d], lk_v[d], to_v[d], per_v[d], ht_v[d]} !== 20'd0) begin
            errors++;
            $display("FAIL %s[%0d]: rp=%0b fp=%0b lk=%0b to=%0b per=%0d ht=%0d required all 0",
                     tag, d, rp_v[d], fp_v[d], lk_v[d], to_v[d], per_v[d], ht_v[d]);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset_hold");
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset_release");
      model_reset();
   endtask

   task automatic test_lock_div2();
      fork
         drive(0, 2, 1, 6);
         chk(0, 6);
      join
   endtask

   task automatic test_unlock_relock();
      fork
         begin
            drive(0, 2, 1, 6);
            drive(0, 4, 2, 1);
            drive(0, 2, 1, 5);
         end
         chk(0, 12);
      join
   endtask

   task automatic test_tolerance();
      fork
         for (int i = 0; i < 6; i++) begin
            drive(1, 2, 1, 1);
            drive(1, 3, 1, 1);
         end
         chk(1, 12);
      join
   endtask

   task automatic test_timeout();
      int w;
      fork
         drive(2, 2, 1, 6);
         chk(2, 6);
      join
      // chk returns one negedge after the final rise_pulse was seen.
      w = 1;
      while (!to_v[2] && w < 40) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (to_v[2] !== 1'b1 || w != 15) begin
         errors++;
         $display("FAIL timeout_delay: timeout=%0b after %0d cycles, required 1 after 15", to_v[2], w);
      end
      checks++;
      if (lk_v[2] !== 1'b0) begin
         errors++;
         $display("FAIL timeout_unlock: got locked=%0b required 0", lk_v[2]);
      end
      fork
         drive(2, 2, 1, 6);
         chk(2, 6);
      join
   endtask

   task automatic test_fall();
      int falls;
      int exp_falls;
      logic [7:0] exp_ht;
`ifdef SLOW_CLOCK_MONITOR_FALL_EN
      exp_falls = 4;
      exp_ht    = 8'd3;
`else
      exp_falls = 0;
      exp_ht    = 8'd0;
`endif
      falls = 0;
      fork
         drive(0, 8, 3, 4);
         chk(0, 4);
         for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            if (fp_v[0]) begin
               falls++;
               checks++;
               if (ht_v[0] !== exp_ht) begin
                  errors++;
                  $display("FAIL high_time: got %0d required %0d", ht_v[0], exp_ht);
               end
            end
         end
      join
      checks++;
      if (falls != exp_falls) begin
         errors++;
         $display("FAIL fall_count: got %0d required %0d", falls, exp_falls);
      end
      checks++;
      if (ht_v[0] !== exp_ht) begin
         errors++;
         $display("FAIL high_time_final: got %0d required %0d", ht_v[0], exp_ht);
      end
   endtask

   task automatic test_reset_midlock();
      fork
         drive(0, 2, 1, 6);
         chk(0, 6);
      join
      #2 rst = 1'b1;
      #1 check_all_zero("reset_async");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      fork
         drive(0, 2, 1, 2);
         chk(0, 2);
      join
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lock_div2();
      test_unlock_relock();
      test_tolerance();
      test_timeout();
      test_fall();
      test_reset_midlock();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

`default_nettype wire
